mem_bus_arbiter: RTL and testbench

//  Shares the single core memory port between instruction fetch (IF) and load/store (LSU).

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_bus_arbiter_if.sv | 61 ++++++
 rtl/arb_fair_sel.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings for the memory bus arbiter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Wide all-ones constant; users slice the low DATA_W/8 bits for the fetch byte enable.
  localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - fetch, load/store and memory port bundle of the arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction fetch side
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_err;

  // Load/store side
  logic                  lsu_req;
  logic                  lsu_we;
  logic [DATA_W/8-1:0]   lsu_be;
  logic [ADDR_W-1:0]     lsu_addr;
  logic [DATA_W-1:0]     lsu_wdata;
  logic                  lsu_gnt;
  logic                  lsu_rvalid;
  logic [DATA_W-1:0]     lsu_rdata;
  logic                  lsu_err;

  // Memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_err;

  logic                  busy;

  // Arbiter view
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output busy
  );

  // Requesters plus memory model view
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  busy
  );

endinterface

// File: rtl/arb_fair_sel.sv
// rtl/arb_fair_sel.sv - LSU-priority selection with an anti-starvation counter for fetch
module arb_fair_sel #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic lsu_req,
  input  logic grant_en,
  output logic sel_if,
  output logic sel_lsu
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // LSU wins ties unless fetch has already been passed over STARVE_LIMIT times in a row
  always_comb begin
    sel_if  = grant_en && if_req && (!lsu_req || (starve_cnt_q == CNT_MAX));
    sel_lsu = grant_en && lsu_req && !sel_if;
  end

  // Count LSU grants that bypass a waiting fetch; any fetch grant or idle fetch clears it
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_en) begin
      if (!if_req || sel_if) begin
        starve_cnt_d = '0;
      end else if (sel_lsu && (starve_cnt_q != CNT_MAX)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding arbiter of fetch and load/store onto one memory port
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int               BE_W     = DATA_W / 8;
  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                lsu_rvalid_q, lsu_rvalid_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                lsu_err_q, lsu_err_d;

  logic                grant_en;
  logic                sel_if, sel_lsu;
  logic                resp_fire;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

  // Grants are only offered from IDLE and are forced low while reset is asserted
  assign grant_en = rst && (state_q == ST_IDLE);

  arb_fair_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk      (clk),
    .rst      (rst),
    .if_req   (bus.if_req),
    .lsu_req  (bus.lsu_req),
    .grant_en (grant_en),
    .sel_if   (sel_if),
    .sel_lsu  (sel_lsu)
  );

  // Next-state, payload latch, timeout counter and response routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tmo_d        = tmo_q;
    resp_fire    = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = '0;
    if_err_d     = 1'b0;
    lsu_rvalid_d = 1'b0;
    lsu_rdata_d  = '0;
    lsu_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_if) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          be_d    = BE_ALL[BE_W-1:0];
          addr_d  = bus.if_addr;
          wdata_d = '0;
          state_d = ST_REQ;
        end else if (sel_lsu) begin
          owner_d = OWN_LSU;
          we_d    = bus.lsu_we;
          be_d    = bus.lsu_be;
          addr_d  = bus.lsu_addr;
          wdata_d = bus.lsu_wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          tmo_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_rvalid) begin
          resp_fire  = 1'b1;
          resp_rdata = bus.mem_rdata;
          resp_err   = bus.mem_err;
          state_d    = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (resp_fire) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = resp_rdata;
        if_err_d    = resp_err;
      end else begin
        lsu_rvalid_d = 1'b1;
        lsu_rdata_d  = resp_rdata;
        lsu_err_d    = resp_err;
      end
    end
  end

  // State and output registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tmo_q        <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
      lsu_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tmo_q        <= tmo_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_rdata_q  <= lsu_rdata_d;
      lsu_err_q    <= lsu_err_d;
    end
  end

  assign bus.if_gnt     = sel_if;
  assign bus.lsu_gnt    = sel_lsu;
  assign bus.mem_req    = (state_q == ST_REQ);
  assign bus.mem_we     = we_q;
  assign bus.mem_be     = be_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_err     = if_err_q;
  assign bus.lsu_rvalid = lsu_rvalid_q;
  assign bus.lsu_rdata  = lsu_rdata_q;
  assign bus.lsu_err    = lsu_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized checks of mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   failed    = 0;
  int   starve    = 0;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu_new();
    bus.lsu_req   = 1'b1;
    bus.lsu_we    = 1'($urandom_range(0, 1));
    bus.lsu_be    = 4'($urandom);
    bus.lsu_addr  = $urandom;
    bus.lsu_wdata = $urandom;
  endtask

  // Who should win this IDLE cycle, and how the pass-over count evolves
  function automatic logic pick();
    logic w;
    if (bus.if_req && bus.lsu_req) w = (starve == STARVE_LIMIT);
    else                           w = bus.if_req;
    if (w || !bus.if_req)           starve = 0;
    else if (starve < STARVE_LIMIT) starve = starve + 1;
    return w;
  endfunction

  // One transaction starting in an IDLE cycle with requests already driven.
  // rv_dly: cycles after RESP entry at which mem_rvalid pulses (<0 = never).
  task automatic txn(input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                     input logic merr, input logic keep, output logic won_if);
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata;
    logic        tmo;
    int          resp_cycles;
    won_if = pick();
    if (won_if) begin
      exp_we = 1'b0; exp_be = 4'hF; exp_addr = bus.if_addr; exp_wdata = 32'h0;
    end else begin
      exp_we = bus.lsu_we; exp_be = bus.lsu_be; exp_addr = bus.lsu_addr; exp_wdata = bus.lsu_wdata;
    end
    #1;
    check("if_gnt", bus.if_gnt, won_if);
    check("lsu_gnt", bus.lsu_gnt, !won_if);
    step();
    if (won_if) begin
      bus.if_req  = keep;
      bus.if_addr = $urandom;
    end else begin
      lsu_new();
      bus.lsu_req = keep;
    end
    for (int c = 0; c <= gnt_dly; c++) begin
      bus.mem_gnt = (c == gnt_dly);
      #1;
      check("mem_req", bus.mem_req, 1);
      check("mem_addr", bus.mem_addr, exp_addr);
      check("mem_we", bus.mem_we, exp_we);
      check("mem_be", bus.mem_be, exp_be);
      if (!won_if) check("mem_wdata", bus.mem_wdata, exp_wdata);
      check("no_gnt_busy", {bus.if_gnt, bus.lsu_gnt}, 0);
      step();
    end
    bus.mem_gnt = 1'b0;
    tmo         = (rv_dly < 0) || (rv_dly >= TIMEOUT);
    resp_cycles = tmo ? TIMEOUT : rv_dly + 1;
    for (int c = 0; c < resp_cycles; c++) begin
      bus.mem_rvalid = (c == rv_dly);
      bus.mem_rdata  = rd;
      bus.mem_err    = merr;
      #1;
      check("rvalid_early", {bus.if_rvalid, bus.lsu_rvalid}, 0);
      check("resp_mem_req", bus.mem_req, 0);
      check("resp_busy", bus.busy, 1);
      check("resp_addr", bus.mem_addr, exp_addr);
      step();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
    bus.mem_err    = 1'b0;
    #1;
    check("if_rvalid", bus.if_rvalid, won_if);
    check("lsu_rvalid", bus.lsu_rvalid, !won_if);
    check("if_rdata", bus.if_rdata, (won_if && !tmo) ? rd : 32'h0);
    check("lsu_rdata", bus.lsu_rdata, (!won_if && !tmo) ? rd : 32'h0);
    check("if_err", bus.if_err, won_if && (tmo || merr));
    check("lsu_err", bus.lsu_err, !won_if && (tmo || merr));
    check("done_busy", bus.busy, 0);
  endtask

  // An IDLE cycle with nobody requesting: no bus activity, no responses
  task automatic idle_check(input string tag);
    step();
    #1;
    check({tag, "_mem_req"}, bus.mem_req, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_rvalid"}, {bus.if_rvalid, bus.lsu_rvalid}, 0);
    starve = 0;
  endtask

  initial begin
    logic       w;
    logic [0:9] order_exp;
    bus.if_req = 0; bus.if_addr = 0;
    bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_be = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_err = 0;

    // Reset state, with a request held to show grants are suppressed
    bus.if_req = 1'b1;
    #2;
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rvalid", {bus.if_rvalid, bus.lsu_rvalid}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be", bus.mem_be, 0);
    bus.if_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    idle_check("post_rst");

    // 1: IF read, minimum latency
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    txn(0, 0, 32'hDEADBEEF, 1'b0, 1'b0, w);
    idle_check("t1_after");

    // 6: bus error on an IF read, then no retry
    bus.if_req = 1'b1; bus.if_addr = 32'h440;
    txn(0, 1, 32'h12345678, 1'b1, 1'b0, w);
    idle_check("t6_noretry_a");
    idle_check("t6_noretry_b");

    // 2: LSU write with mem_gnt three cycles late
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_be = 4'b0011;
    bus.lsu_addr = 32'h2000; bus.lsu_wdata = 32'hA5A5_0F0F;
    txn(3, 0, 32'h0, 1'b0, 1'b0, w);

    // 4: LSU read that never gets a response, then a stray late mem_rvalid
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_be = 4'hF; bus.lsu_addr = 32'h3000;
    txn(0, -1, 32'hCAFE_F00D, 1'b0, 1'b0, w);
    idle_check("t4_idle");
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    #1;
    check("t4_stray_busy", bus.busy, 0);
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    check("t4_stray_rvalid", {bus.if_rvalid, bus.lsu_rvalid}, 0);
    check("t4_stray_rdata", bus.lsu_rdata, 0);
    starve = 0;

    // Response in the very last RESP cycle before the timeout fires
    lsu_new();
    txn(1, TIMEOUT - 1, 32'h7777_1234, 1'b0, 1'b0, w);

    // 3: both requesters held continuously
    order_exp = 10'b0000100001;
    bus.if_req = 1'b1; bus.if_addr = $urandom;
    lsu_new();
    for (int i = 0; i < 10; i++) begin
      txn(0, 0, $urandom, 1'b0, 1'b1, w);
      check("t3_order", w, order_exp[i]);
    end
    bus.if_req = 1'b0; bus.lsu_req = 1'b0;
    idle_check("t3_idle");

    // Randomized traffic, including withdrawn requests and timeouts
    for (int t = 0; t < 40; t++) begin
      if (!bus.if_req && ($urandom_range(0, 1) == 1)) begin
        bus.if_req = 1'b1; bus.if_addr = $urandom;
      end
      if (!bus.lsu_req && ($urandom_range(0, 1) == 1)) lsu_new();
      else if (bus.lsu_req && ($urandom_range(0, 7) == 0)) bus.lsu_req = 1'b0;
      if (!bus.if_req && !bus.lsu_req) begin
        bus.if_req = 1'b1; bus.if_addr = $urandom;
      end
      txn($urandom_range(0, 3), $urandom_range(0, 9), $urandom,
          ($urandom_range(0, 3) == 0), 1'b0, w);
    end
    bus.if_req = 1'b0; bus.lsu_req = 1'b0;
    idle_check("rand_idle");

    // 5: asynchronous reset in the middle of RESP
    bus.if_req = 1'b1; bus.if_addr = 32'h900;
    w = pick();
    #1;
    check("t5_if_gnt", bus.if_gnt, 1);
    step();
    bus.if_req = 1'b0; bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h904;
    #1;
    check("t5_busy_before", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("t5_rst_mem_req", bus.mem_req, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_gnt", {bus.if_gnt, bus.lsu_gnt}, 0);
    check("t5_rst_rvalid", {bus.if_rvalid, bus.lsu_rvalid}, 0);
    check("t5_rst_addr", bus.mem_addr, 0);
    rst = 1'b1;
    starve = 0;
    txn(0, 0, 32'hBEEF_0001, 1'b0, 1'b0, w);
    idle_check("t5_after");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
